// File: rtl/draw_seq_pkg.sv
`default_nettype none
// ============================================================================
// draw_seq_pkg: shared types and constants for the draw sequencer.
// Rev 1.0
// ============================================================================
package draw_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_START  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   localparam int NUM_STAGES = 3;
   localparam int X_W        = 8;
   localparam int Y_W        = 7;
   localparam int COLOUR_W   = 18;

   localparam logic [1:0] STAGE_CLEAR     = 2'd0;
   localparam logic [1:0] STAGE_SCENE     = 2'd1;
   localparam logic [1:0] STAGE_CROSSHAIR = 2'd2;

endpackage
`default_nettype wire

// File: rtl/vga_port_mux.sv
`default_nettype none
// ============================================================================
// vga_port_mux: picks one client's pixel-write signals, zeros when not valid.
// Rev 1.0
// ============================================================================
module vga_port_mux
   import draw_seq_pkg::*;
(
   input  logic [1:0]                     sel,
   input  logic                           valid,
   input  logic [NUM_STAGES*X_W-1:0]      client_x,
   input  logic [NUM_STAGES*Y_W-1:0]      client_y,
   input  logic [NUM_STAGES*COLOUR_W-1:0] client_colour,
   input  logic [NUM_STAGES-1:0]          client_write,
   output logic [X_W-1:0]                 vga_x,
   output logic [Y_W-1:0]                 vga_y,
   output logic [COLOUR_W-1:0]            vga_colour,
   output logic                           vga_write
);

   always_comb begin
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_write  = 1'b0;
      if (valid) begin
         case (sel)
            STAGE_CLEAR: begin
               vga_x      = client_x[X_W-1:0];
               vga_y      = client_y[Y_W-1:0];
               vga_colour = client_colour[COLOUR_W-1:0];
               vga_write  = client_write[0];
            end
            STAGE_SCENE: begin
               vga_x      = client_x[2*X_W-1:X_W];
               vga_y      = client_y[2*Y_W-1:Y_W];
               vga_colour = client_colour[2*COLOUR_W-1:COLOUR_W];
               vga_write  = client_write[1];
            end
            STAGE_CROSSHAIR: begin
               vga_x      = client_x[3*X_W-1:2*X_W];
               vga_y      = client_y[3*Y_W-1:2*Y_W];
               vga_colour = client_colour[3*COLOUR_W-1:2*COLOUR_W];
               vga_write  = client_write[2];
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
// draw_sequencer: per-frame scheduler running clear/scene/crosshair clients
// in fixed order over the shared VGA write port. Rev 1.0
// ============================================================================
module draw_sequencer
   import draw_seq_pkg::*;
#(
   parameter int TIMEOUT = 20000
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           frame_tick,
   input  logic [NUM_STAGES-1:0]          stage_enable,
   output logic [NUM_STAGES-1:0]          client_start,
   input  logic [NUM_STAGES-1:0]          client_done,
   input  logic [NUM_STAGES*X_W-1:0]      client_x,
   input  logic [NUM_STAGES*Y_W-1:0]      client_y,
   input  logic [NUM_STAGES*COLOUR_W-1:0] client_colour,
   input  logic [NUM_STAGES-1:0]          client_write,
   output logic [X_W-1:0]                 vga_x,
   output logic [Y_W-1:0]                 vga_y,
   output logic [COLOUR_W-1:0]            vga_colour,
   output logic                           vga_write,
   output logic                           busy,
   output logic                           frame_done,
   output logic                           timeout_error,
   output logic [7:0]                     overrun_count
);

   localparam int             WD_W    = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t                state, state_n;
   logic [1:0]            k, k_n;
   logic [NUM_STAGES-1:0] mask, mask_n;
   logic                  pending, pending_n;
   logic [WD_W-1:0]       wd, wd_n;
   logic                  set_error, overrun_inc, advance, mux_valid;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         k             <= STAGE_CLEAR;
         mask          <= '0;
         pending       <= 1'b0;
         wd            <= '0;
         timeout_error <= 1'b0;
         overrun_count <= '0;
      end else begin
         state   <= state_n;
         k       <= k_n;
         mask    <= mask_n;
         pending <= pending_n;
         wd      <= wd_n;
         if (set_error)
            timeout_error <= 1'b1;
         if (overrun_inc && overrun_count != 8'hFF)
            overrun_count <= overrun_count + 8'd1;
      end
   end

   always_comb begin
      state_n      = state;
      k_n          = k;
      mask_n       = mask;
      pending_n    = pending;
      wd_n         = wd;
      set_error    = 1'b0;
      overrun_inc  = 1'b0;
      advance      = 1'b0;
      client_start = '0;
      frame_done   = 1'b0;
      busy         = (state != ST_IDLE);

      if ((state == ST_START || state == ST_WAIT) && frame_tick) begin
         if (pending)
            overrun_inc = 1'b1;
         else
            pending_n = 1'b1;
      end

      case (state)
         ST_IDLE: begin
            if (frame_tick || pending) begin
               mask_n    = stage_enable;
               k_n       = STAGE_CLEAR;
               pending_n = 1'b0;
               state_n   = ST_START;
            end
         end
         ST_START: begin
            if (mask[k]) begin
               client_start[k] = 1'b1;
               wd_n            = '0;
               state_n         = ST_WAIT;
            end else begin
               advance = 1'b1;
            end
         end
         ST_WAIT: begin
            // A done arriving in the expiry cycle wins over the watchdog.
            if (client_done[k]) begin
               advance = 1'b1;
            end else if (wd == WD_LAST) begin
               set_error = 1'b1;
               advance   = 1'b1;
            end else begin
               wd_n = wd + 1'b1;
            end
         end
         ST_FINISH: begin
            frame_done = 1'b1;
            // A tick landing in this cycle counts as pending and starts the next frame.
            if (pending || frame_tick) begin
               mask_n    = stage_enable;
               k_n       = STAGE_CLEAR;
               pending_n = pending && frame_tick;
               state_n   = ST_START;
            end else begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (advance) begin
         if (k == STAGE_CROSSHAIR) begin
            state_n = ST_FINISH;
         end else begin
            k_n     = k + 2'd1;
            state_n = ST_START;
         end
      end
   end

   assign mux_valid = (state == ST_START || state == ST_WAIT) && mask[k];

   vga_port_mux u_mux (
      .sel           (k),
      .valid         (mux_valid),
      .client_x      (client_x),
      .client_y      (client_y),
      .client_colour (client_colour),
      .client_write  (client_write),
      .vga_x         (vga_x),
      .vga_y         (vga_y),
      .vga_colour    (vga_colour),
      .vga_write     (vga_write)
   );

endmodule
`default_nettype wire

// File: doc/draw_sequencer.md
# draw_sequencer

Per-frame scheduler for the shared VGA adapter write port. On each frame tick it runs up to three drawing clients in fixed order: stage 0 clear, stage 1 scene, stage 2 crosshair (`draw_crosshair`). Each client gets a one-cycle `start` and must answer with `done`. While a stage is active, that stage's client owns the VGA pixel-write signals through a registered-select multiplexer. The block sits between the game top level and the VGA adapter and replaces ad-hoc wiring of the draw units.

## Interface
- `TIMEOUT`, default 20000: maximum cycles a stage may spend waiting for `done`; covers 160×120 = 19200 pixels plus margin. Must be ≥ 2.
- `clock`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `frame_tick`  input  1  one-cycle pulse requesting a new frame draw.
- `stage_enable`  input  3  bit k enables stage k; sampled only when a frame starts.
- `client_start`  output  3  bit k is the one-cycle start pulse to client k.
- `client_done`  input  3  bit k is the done indication from client k.
- `client_x`  input  24  packed: client k drives bits [8k+7:8k].
- `client_y`  input  21  packed: client k drives bits [7k+6:7k].
- `client_colour`  input  54  packed: client k drives bits [18k+17:18k].
- `client_write`  input  3  per-client write strobe.
- `vga_x`, `vga_y`, `vga_colour`, `vga_write`  outputs  8 / 7 / 18 / 1  to the VGA adapter.
- `busy`  output  1  high from the frame start cycle through the FINISH cycle inclusive.
- `frame_done`  output  1  one-cycle pulse when a frame completes.
- `timeout_error`  output  1  sticky; set on any watchdog abort; cleared only by reset.
- `overrun_count`  output  8  saturating count of dropped frame ticks.

## Operation
- **States:** IDLE, START, WAIT, FINISH, plus a 2-bit stage index `k` (0..2) and a latched 3-bit enable mask.
- **IDLE:**
  - Wait for `frame_tick`, or for a pending tick.
  - On a tick: latch `stage_enable`, set `k` = 0, go to START.
- **START(k):**
  - If the mask bit is set: assert `client_start[k]` for this cycle only, then go to WAIT.
  - If the mask bit is clear: no pulse; the stage is skipped at a cost of 1 cycle. Advance `k`, or go to FINISH after stage 2.
- **WAIT(k):**
  - Sample `client_done[k]`. When it is high, advance to START(k+1), or to FINISH after stage 2.
  - `done` from any other client is ignored.
  - The watchdog counter clears on entry and increments each WAIT cycle. When it reaches `TIMEOUT`−1 with no `done`: set `timeout_error`, abort the stage, and advance exactly as if `done` had arrived.
- **FINISH:**
  - Pulse `frame_done`.
  - If a tick is pending: clear it and go straight to START(0) with a freshly latched enable mask.
  - Otherwise go to IDLE.
- **Frame tick while busy:**
  - If no tick is pending: set the single-deep pending flag.
  - If one is already pending: increment `overrun_count`, saturating at 255.
  - A tick in the same cycle as FINISH is treated as pending, so it starts the next frame immediately.
- **Mux:**
  - In START(k) and WAIT(k) with the stage enabled: `vga_*` = client k's signals, combinational from the registered select.
  - Otherwise `vga_write` = 0 and x, y and colour = 0.
  - Writes during a skipped START are blocked.
- **Reset mid-frame:** immediate return to IDLE. All outputs go to 0, the pending flag clears, and the counters and error flag clear. Clients are not notified.

## Timing
- Reset values: every output is 0.
- `frame_tick` at edge t (state IDLE):
  - START(0) and `client_start[0]` during cycle t+1.
  - WAIT(0) from t+2.
- `client_done[k]` high in cycle c of WAIT: START(k+1) in cycle c+1.
- Fixed overhead per enabled stage: 1 START cycle plus at least 1 WAIT cycle.
  - All enabled, each `done` arrives in the first WAIT cycle: frame_tick → `frame_done` = 7 cycles (t+1..t+7, FINISH at t+7).
  - All disabled: START×3 then FINISH, with `frame_done` at t+4.
- `done` asserted during a START cycle is ignored.
- A `done` that arrives in the same cycle as the watchdog expiry counts as `done`: no error.

## Structure
- Package `draw_seq_pkg` holds:
  - the state enum;
  - stage index constants (`STAGE_CLEAR`=0, `STAGE_SCENE`=1, `STAGE_CROSSHAIR`=2);
  - `NUM_STAGES`=3;
  - widths X_W=8, Y_W=7, COLOUR_W=18.
- Sub-module `vga_port_mux`: selects one client's x/y/colour/write from an index plus a valid flag, and outputs zeros when the flag is invalid.

## Test plan
- **Reset mid-WAIT(1):** assert `reset` low → all outputs 0 in the same cycle; after release, IDLE and no `client_start` until the next tick.
- **Normal frame:**
  - Stimulus: mask 3'b111, clients answer `done` 5, 10 and 3 cycles after their start pulse, frame_tick at cycle 10.
  - Required: starts at cycles 11, 17 and 28; `frame_done` at 32; `vga_*` track the active client only.
- **Skipped stage:**
  - Stimulus: mask 3'b101, with `client_write[1]` held high throughout.
  - Required: no `client_start[1]` pulse, `vga_write` never sourced from client 1, and the skip costs exactly 1 cycle.
- **Overrun:**
  - Stimulus: 3 ticks during one busy frame.
  - Required: `overrun_count` = 2; the next frame starts in the cycle after FINISH.
  - Also: 300 excess ticks → `overrun_count` saturates at 255.
- **Watchdog (`TIMEOUT`=8):**
  - Stimulus: client 1 never answers.
  - Required: stage aborts after 8 WAIT cycles, `timeout_error` = 1, stage 2 starts next.
  - Also: `done` in the expiry cycle → no error.
- **Edge cases:**
  - `done` asserted during the START cycle only → ignored; the stage keeps waiting.
  - `done[2]` during WAIT(0) → ignored.
